// File: rtl/spi_parity_pkg.sv
// Shared definitions for the SPI odd-parity transmitter: FSM encoding, default sizing, parity helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_parity_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CLK_DIV_DEF = 2;
  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  // Parity bit that makes the total count of ones (word + parity) odd.
  function automatic logic odd_par(input logic [PAR_MAX_W-1:0] word);
    return ~^word;
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Bit-period timer: holds each serial bit for CLK_DIV cycles and flags the final cycle.
// Latency: load/en describe the coming cycle; last is registered and valid in that cycle.
// Backpressure: none; runs whenever en is high, idles at zero otherwise.
module spi_bit_timer
  import spi_parity_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  // Count down from CLK_DIV to 1 within a bit; drop to 0 whenever not enabled.
  always_comb begin
    cnt_d = '0;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
    last_d = (cnt_d == ONE);
  end

  // Timer state; last is precomputed so it leaves a flop directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign last = last_q;

endmodule

// File: rtl/spi_parity_odd_tx.sv
// SPI-style transmitter: cs low, DATA_W data bits, one odd-parity bit, cs high. Macro SPI_PARITY_TX_LSB_FIRST_EN selects LSB-first data order.
// Latency: cs falls one cycle after start is accepted; frame occupies 2 + (DATA_W+1)*CLK_DIV cycles.
// Backpressure: start is honoured only in IDLE; requests while busy are dropped, not queued.
module spi_parity_odd_tx
  import spi_parity_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              cs,
  output logic              sample,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              cs_q, cs_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_last;
  logic              tmr_en, tmr_load;
  logic              next_bit;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: frame sequencing driven by the bit timer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_DATA;
      ST_DATA:   if (bit_last && (bit_cnt_q == LAST_BIT)) state_d = ST_PARITY;
      ST_PARITY: if (bit_last) state_d = ST_GAP;
      ST_GAP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture word and parity on accept, shift after each data bit.
  always_comb begin
    shreg_d   = shreg_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      shreg_d   = data;
      par_d     = odd_par(PAR_MAX_W'(data));
      bit_cnt_d = '0;
    end else if ((state_q == ST_DATA) && bit_last) begin
`ifdef SPI_PARITY_TX_LSB_FIRST_EN
      shreg_d   = shreg_q >> 1;
`else
      shreg_d   = shreg_q << 1;
`endif
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BIT_ONE;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Timer runs for every cycle spent in DATA or PARITY and reloads at each bit start.
  assign tmr_en   = (state_d == ST_DATA) || (state_d == ST_PARITY);
  assign tmr_load = tmr_en && ((state_q == ST_SETUP) || bit_last);

  spi_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .en    (tmr_en),
    .last  (bit_last)
  );

`ifdef SPI_PARITY_TX_LSB_FIRST_EN
  assign next_bit = shreg_d[0];
`else
  assign next_bit = shreg_d[DATA_W-1];
`endif

  // Output decode from the upcoming state so every output leaves a flop aligned with it.
  always_comb begin
    cs_d   = 1'b1;
    out_d  = 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_GAP);
    case (state_d)
      ST_SETUP:  cs_d = 1'b0;
      ST_DATA:   begin cs_d = 1'b0; out_d = next_bit; end
      ST_PARITY: begin cs_d = 1'b0; out_d = par_d; end
      default:   cs_d = 1'b1;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q   <= 1'b1;
      out_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cs_q   <= cs_d;
      out_q  <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign cs     = cs_q;
  assign sample = bit_last;
  assign out    = out_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_spi_parity_odd_tx.sv
// Self-checking bench for spi_parity_odd_tx: default build plus a DATA_W=4 / CLK_DIV=1 instance.
// Expected waveforms come from a frame-level model (bit order, parity by popcount, cycle positions).
// Inputs change 1 time unit after posedge; outputs are checked at the same point.
module tb_spi_parity_odd_tx;

  logic       clk;
  logic       reset;
  logic       start, start_s;
  logic [7:0] data;
  logic [3:0] data_s;
  logic       cs, sample, out_w, busy, done;
  logic       cs_s, sample_s, out_s, busy_s, done_s;

  int checks = 0;
  int errors = 0;

  spi_parity_odd_tx dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data   (data),
    .cs     (cs),
    .sample (sample),
    .out    (out_w),
    .busy   (busy),
    .done   (done)
  );

  spi_parity_odd_tx #(
    .DATA_W  (4),
    .CLK_DIV (1)
  ) dut_s (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .data   (data_s),
    .cs     (cs_s),
    .sample (sample_s),
    .out    (out_s),
    .busy   (busy_s),
    .done   (done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {cs,sample,out,busy,done} in frame cycle c (1 = cycle after the accepting edge).
  function automatic logic [4:0] exp_vec(input int c, input int w, input int cd, input logic [63:0] d);
    int          fl;
    int          k;
    int          idx;
    logic [63:0] mask;
    logic        b;
    fl   = 2 + (w + 1) * cd;
    mask = (64'd1 << w) - 64'd1;
    if (c == 1) return 5'b00010;
    if (c >= 2 && c < fl) begin
      k   = c - 2;
      idx = k / cd;
      if (idx < w) begin
`ifdef SPI_PARITY_TX_LSB_FIRST_EN
        b = d[idx];
`else
        b = d[w - 1 - idx];
`endif
      end else begin
        b = (($countones(d & mask) % 2) == 0);
      end
      return {1'b0, (k % cd) == (cd - 1), b, 1'b1, 1'b0};
    end
    if (c == fl) return 5'b10011;
    return 5'b10000;
  endfunction

  // One frame on the default instance; extra start pulses at frame cycles x1/x2 must be ignored.
  task automatic frame(input logic [7:0] d, input int x1, input int x2, input int exp_par);
    int   n;
    int   ones;
    logic lastb;
    start = 1'b1;
    data  = d;
    tick();
    start = 1'b0;
    data  = 8'($urandom);
    n     = 0;
    ones  = 0;
    lastb = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      chk($sformatf("frame_%02h_c%0d", d, c), 64'({cs, sample, out_w, busy, done}),
          64'(exp_vec(c, 8, 2, 64'(d))));
      if (sample === 1'b1) begin
        n++;
        ones += int'(out_w);
        lastb = out_w;
      end
      if (c < 21) begin
        start = (c == x1) || (c == x2);
        if (start) data = 8'($urandom);
        tick();
      end
    end
    start = 1'b0;
    chk($sformatf("strobes_%02h", d), 64'(n), 64'd9);
    chk($sformatf("rx_odd_%02h", d), 64'(ones % 2), 64'd1);
    if (exp_par >= 0) chk($sformatf("parity_%02h", d), 64'(lastb), 64'(exp_par));
  endtask

  // One frame on the DATA_W=4, CLK_DIV=1 instance.
  task automatic frame_s(input logic [3:0] d, input int exp_par);
    int   n;
    int   ones;
    int   busy_n;
    logic lastb;
    start_s = 1'b1;
    data_s  = d;
    tick();
    start_s = 1'b0;
    data_s  = 4'($urandom);
    n       = 0;
    ones    = 0;
    busy_n  = 0;
    lastb   = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("small_%01h_c%0d", d, c), 64'({cs_s, sample_s, out_s, busy_s, done_s}),
          64'(exp_vec(c, 4, 1, 64'(d))));
      if (sample_s === 1'b1) begin
        n++;
        ones += int'(out_s);
        lastb = out_s;
      end
      if (busy_s === 1'b1) busy_n++;
      if (c < 8) tick();
    end
    chk($sformatf("small_strobes_%01h", d), 64'(n), 64'd5);
    chk($sformatf("small_busy_%01h", d), 64'(busy_n), 64'd7);
    chk($sformatf("small_rx_odd_%01h", d), 64'(ones % 2), 64'd1);
    if (exp_par >= 0) chk($sformatf("small_parity_%01h", d), 64'(lastb), 64'(exp_par));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    start_s = 1'b0;
    data    = '0;
    data_s  = '0;

    // Reset held for two edges, then idle.
    tick();
    tick();
    chk("reset_main", 64'({cs, sample, out_w, busy, done}), 64'(5'b10000));
    chk("reset_small", 64'({cs_s, sample_s, out_s, busy_s, done_s}), 64'(5'b10000));
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle_main_%0d", i), 64'({cs, sample, out_w, busy, done}), 64'(5'b10000));
      chk($sformatf("idle_small_%0d", i), 64'({cs_s, sample_s, out_s, busy_s, done_s}), 64'(5'b10000));
    end

    // Directed words, back to back; each next frame launches on the first IDLE cycle.
    frame(8'hA5, 0, 0, 1);
    frame(8'h07, 0, 0, 0);
    frame(8'h00, 0, 0, 1);
    frame(8'hFF, 0, 0, 1);
    // Starts during the frame are dropped.
    frame(8'hA5, 5, 19, 1);
    frame(8'h5A, 0, 0, 1);

    // Reset during data bit 4 (frame cycle 10).
    start = 1'b1;
    data  = 8'hA5;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("pre_reset_c10", 64'({cs, sample, out_w, busy, done}), 64'(exp_vec(10, 8, 2, 64'h00A5)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset", 64'({cs, sample, out_w, busy, done}), 64'(5'b10000));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_reset_%0d", i), 64'({cs, sample, out_w, busy, done}), 64'(5'b10000));
    end
    frame(8'h3C, 0, 0, 1);

    // Reset and start on the same edge: reset wins.
    reset = 1'b1;
    start = 1'b1;
    data  = 8'hFF;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("reset_vs_start", 64'({cs, sample, out_w, busy, done}), 64'(5'b10000));
    tick();
    chk("reset_vs_start_n", 64'({cs, sample, out_w, busy, done}), 64'(5'b10000));

    // CLK_DIV=1, DATA_W=4.
    frame_s(4'b1011, 0);
    frame_s(4'b0000, 1);

    // Randomized words on both instances.
    for (int i = 0; i < 4; i++) begin
      frame(8'($urandom), 0, 0, -1);
      frame_s(4'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
